// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared state encoding and default operand width for the
//                adder/subtractor family.
//  Revision    : 1.0  initial release
// ============================================================================
package adder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : Single-bit combinational full subtractor (a - b - bin).
//  Revision    : 1.0  initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow out of this bit position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial WIDTH-bit subtractor, D = A - B - Bin, LSB first,
//                one bit per clock with a start/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_br;
    logic             w_diff;
    logic             w_br_next;
    logic             w_load;
    logic             w_last;

    // A new operation is accepted whenever the block is not mid-subtraction
    assign w_load = start && (r_state != RUN);
    // Final bit of the current operation (MSB position)
    assign w_last = (r_state == RUN) && (r_cnt == C_LAST);

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

    // The one and only subtractor cell, reused for every bit position
    full_subtractor u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .d    (w_diff),
        .bout (w_br_next)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: DONE lasts one cycle unless immediately restarted
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = w_load ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand shifting, borrow chain, bit counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_cnt <= '0;
            r_br  <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
            V     <= 1'b0;
        end else if (w_load) begin
            r_a   <= A;
            r_b   <= B;
            r_br  <= Bin;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_res <= {w_diff, r_res[WIDTH-1:1]};
            r_br  <= w_br_next;
            r_cnt <= r_cnt + 1'b1;
            // Outputs only move on the final bit; signed overflow is the
            // borrow into the MSB differing from the borrow out of it
            if (w_last) begin
                D    <= {w_diff, r_res[WIDTH-1:1]};
                Bout <= w_br_next;
                V    <= r_br ^ w_br_next;
            end
        end
    end

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor with directed and
//                random operands against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;
    logic         V;

    int n_tests = 0;
    int n_fail  = 0;

    // Values the outputs must hold between completions
    logic [W-1:0] hold_d = '0;
    logic         hold_b = 1'b0;
    logic         hold_v = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout),
        .V     (V)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed readings
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         output logic [W-1:0] ed, output logic eb, output logic ev);
        int ud;
        int sd;
        int sa;
        int sb;
        ud = int'(a) - int'(b) - int'(bi);
        sa = (a[W-1]) ? int'(a) - (1 << W) : int'(a);
        sb = (b[W-1]) ? int'(b) - (1 << W) : int'(b);
        sd = sa - sb - int'(bi);
        ed = W'(ud);
        eb = (ud < 0);
        ev = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, "_D_hold"}, 32'(D), 32'(hold_d));
        chk({tag, "_Bout_hold"}, 32'(Bout), 32'(hold_b));
        chk({tag, "_V_hold"}, 32'(V), 32'(hold_v));
    endtask

    // Runs one operation from the start edge to the done cycle.
    // poke: pulse start with other operands mid-run.
    // chain: leave the bench in the DONE cycle so the caller can restart.
    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic bi, input bit poke, input bit chain);
        logic [W-1:0] ed;
        logic         eb;
        logic         ev;
        model(a, b, bi, ed, eb, ev);
        A = a; B = b; Bin = bi; start = 1'b1;
        tick();
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
        chk({tag, "_busy_load"}, 32'(busy), 32'd1);
        chk({tag, "_done_load"}, 32'(done), 32'd0);
        chk_hold(tag);
        for (int i = 1; i < W; i++) begin
            if (poke && i == 2) begin
                start = 1'b1; A = ~a; B = ~b; Bin = ~bi;
            end
            tick();
            start = 1'b0;
            chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            chk({tag, "_done_run"}, 32'(done), 32'd0);
            chk_hold(tag);
        end
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_D"}, 32'(D), 32'(ed));
        chk({tag, "_Bout"}, 32'(Bout), 32'(eb));
        chk({tag, "_V"}, 32'(V), 32'(ev));
        hold_d = ed; hold_b = eb; hold_v = ev;
        if (!chain) begin
            tick();
            chk({tag, "_done_pulse"}, 32'(done), 32'd0);
            chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
            chk_hold(tag);
        end
    endtask

    // Directed sequence
    initial begin
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_hold("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // Plan vectors
        op("v1", 4'b1001, 4'b0111, 1'b0, 1'b0, 1'b0);
        op("v2", 4'd7, 4'd9, 1'b0, 1'b0, 1'b0);
        op("v3", 4'd5, 4'd5, 1'b1, 1'b0, 1'b0);
        op("v4", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        op("v5", 4'd0, 4'd15, 1'b1, 1'b0, 1'b0);
        op("v6", 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);

        // Start while busy is ignored, a single done pulse follows
        op("poke", 4'd12, 4'd3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("poke_no_done", 32'(done), 32'd0);
            chk("poke_idle", 32'(busy), 32'd0);
        end

        // Back-to-back: start offered in the DONE cycle
        op("b2b_a", 4'd3, 4'd10, 1'b0, 1'b0, 1'b1);
        op("b2b_b", 4'd8, 4'd1, 1'b0, 1'b0, 1'b1);
        op("b2b_c", 4'd6, 4'd6, 1'b0, 1'b0, 1'b0);

        // Reset mid-run aborts and clears outputs immediately
        A = 4'd9; B = 4'd2; Bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        hold_d = '0; hold_b = 1'b0; hold_v = 1'b0;
        chk_hold("arst");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            chk("arst_no_done", 32'(done), 32'd0);
        end
        op("post_rst", 4'd4, 4'd11, 1'b1, 1'b0, 1'b0);

        // Random operands, some chained back-to-back
        for (int i = 0; i < 24; i++) begin
            op("rnd", W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'($urandom));
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
